// File: rtl/mmu_sequencer_if.sv
// Signal bundle between the 2x2 MMU sequencer, its control unit, the systolic array
// and the output byte mux.
interface mmu_sequencer_if;
    logic        start;
    logic [31:0] weights;
    logic [31:0] inputs;
    logic [7:0]  a_row0;
    logic [7:0]  a_row1;
    logic [7:0]  b_col0;
    logic [7:0]  b_col1;
    logic        mmu_clear;
    logic        mmu_valid;
    logic [15:0] c00;
    logic [15:0] c01;
    logic [15:0] c10;
    logic [15:0] c11;
    logic        busy;
    logic        done;
    logic [1:0]  out_sel;
    logic        out_hi;
    logic [7:0]  dout;

    modport master (
        input  start, weights, inputs, c00, c01, c10, c11, out_sel, out_hi,
        output a_row0, a_row1, b_col0, b_col1, mmu_clear, mmu_valid, busy, done, dout
    );

    modport slave (
        output start, weights, inputs, c00, c01, c10, c11, out_sel, out_hi,
        input  a_row0, a_row1, b_col0, b_col1, mmu_clear, mmu_valid, busy, done, dout
    );
endinterface

// File: rtl/mmu_sequencer.sv
// Runs one 2x2 matrix multiply through the systolic MMU: clear, skewed feed, drain,
// capture, then serves the four 16-bit results as bytes.
module mmu_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input logic             clk,
    input logic             rst,
    mmu_sequencer_if.master bus
);
    typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StCapture} state_e;

    localparam logic [2:0] DrainLast = 3'(DRAIN_CYCLES - 1);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       wgt_q, wgt_d;
    logic [31:0]       inp_q, inp_d;
    logic [3:0][15:0]  res_q, res_d;
    logic [7:0]        a_row0_q, a_row0_d, a_row1_q, a_row1_d;
    logic [7:0]        b_col0_q, b_col0_d, b_col1_q, b_col1_d;
    logic              clear_q, clear_d, valid_q, valid_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [15:0]       sel_word;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wgt_d   = wgt_q;
        inp_d   = inp_q;
        res_d   = res_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StClear;
                    wgt_d   = bus.weights;
                    inp_d   = bus.inputs;
                end
            end
            StClear: begin
                state_d = StFeed;
                cnt_d   = 3'd0;
            end
            StFeed: begin
                if (cnt_q == 3'd2) begin
                    state_d = StDrain;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StDrain: begin
                if (cnt_q == DrainLast) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StCapture: begin
                state_d = StIdle;
                res_d   = {bus.c11, bus.c10, bus.c01, bus.c00};
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        a_row0_d = 8'd0;
        a_row1_d = 8'd0;
        b_col0_d = 8'd0;
        b_col1_d = 8'd0;
        clear_d  = (state_d == StClear);
        valid_d  = (state_d == StFeed) || (state_d == StDrain);
        busy_d   = (state_d != StIdle);
        if (state_d == StFeed) begin
            unique case (cnt_d)
                3'd0: begin
                    a_row0_d = wgt_q[7:0];
                    b_col0_d = inp_q[7:0];
                end
                3'd1: begin
                    a_row0_d = wgt_q[15:8];
                    a_row1_d = wgt_q[23:16];
                    b_col0_d = inp_q[23:16];
                    b_col1_d = inp_q[15:8];
                end
                3'd2: begin
                    a_row1_d = wgt_q[31:24];
                    b_col1_d = inp_q[31:24];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            wgt_q    <= 32'd0;
            inp_q    <= 32'd0;
            res_q    <= '0;
            a_row0_q <= 8'd0;
            a_row1_q <= 8'd0;
            b_col0_q <= 8'd0;
            b_col1_q <= 8'd0;
            clear_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wgt_q    <= wgt_d;
            inp_q    <= inp_d;
            res_q    <= res_d;
            a_row0_q <= a_row0_d;
            a_row1_q <= a_row1_d;
            b_col0_q <= b_col0_d;
            b_col1_q <= b_col1_d;
            clear_q  <= clear_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        sel_word = res_q[bus.out_sel];
        bus.dout = bus.out_hi ? sel_word[15:8] : sel_word[7:0];
    end

    assign bus.a_row0    = a_row0_q;
    assign bus.a_row1    = a_row1_q;
    assign bus.b_col0    = b_col0_q;
    assign bus.b_col1    = b_col1_q;
    assign bus.mmu_clear = clear_q;
    assign bus.mmu_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_mmu_sequencer.sv
// Directed bench for mmu_sequencer with a behavioural 2x2 output-stationary array model;
// a second instance built with DRAIN_CYCLES=4 checks the longer drain timing.
module tb_mmu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mmu_sequencer_if bus ();
    mmu_sequencer_if bus4 ();

    mmu_sequencer #(.DRAIN_CYCLES(2)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    mmu_sequencer #(.DRAIN_CYCLES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // Array model: a flows right, b flows down, each PE accumulates a*b when valid.
    logic [7:0]  pa00 = 8'd0, pa10 = 8'd0, pb00 = 8'd0, pb01 = 8'd0;
    logic [15:0] acc00 = 16'd0, acc01 = 16'd0, acc10 = 16'd0, acc11 = 16'd0;

    function automatic logic [15:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] x, y;
        x = 16'(signed'(a));
        y = 16'(signed'(b));
        return x * y;
    endfunction

    always @(posedge clk) begin
        if (bus.mmu_clear) begin
            pa00 <= 8'd0; pa10 <= 8'd0; pb00 <= 8'd0; pb01 <= 8'd0;
            acc00 <= 16'd0; acc01 <= 16'd0; acc10 <= 16'd0; acc11 <= 16'd0;
        end else if (bus.mmu_valid) begin
            acc00 <= acc00 + mul(bus.a_row0, bus.b_col0);
            acc01 <= acc01 + mul(pa00, bus.b_col1);
            acc10 <= acc10 + mul(bus.a_row1, pb00);
            acc11 <= acc11 + mul(pa10, pb01);
            pa00  <= bus.a_row0;
            pa10  <= bus.a_row1;
            pb00  <= bus.b_col0;
            pb01  <= bus.b_col1;
        end
    end

    assign bus.c00 = acc00;
    assign bus.c01 = acc01;
    assign bus.c10 = acc10;
    assign bus.c11 = acc11;

    assign bus4.c00 = 16'd0;
    assign bus4.c01 = 16'd0;
    assign bus4.c10 = 16'd0;
    assign bus4.c11 = 16'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dout(input string tag, input logic [1:0] sel, input logic hi,
                              input logic [7:0] exp);
        bus.out_sel = sel;
        bus.out_hi  = hi;
        #1;
        check(tag, 32'(bus.dout), 32'(exp));
    endtask

    task automatic run_to_done(input logic [31:0] w, input logic [31:0] b, output int lat);
        bus.weights = w;
        bus.inputs  = b;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    function automatic logic [31:0] feeds(input logic unused);
        return {bus.a_row0, bus.a_row1, bus.b_col0, bus.b_col1};
    endfunction

    function automatic logic [31:0] ctrl(input logic unused);
        return 32'({bus.busy, bus.done, bus.mmu_clear, bus.mmu_valid});
    endfunction

    function automatic logic [31:0] ctrl4(input logic unused);
        return 32'({bus4.busy, bus4.done, bus4.mmu_clear, bus4.mmu_valid});
    endfunction

    localparam logic [31:0] WA = 32'h04030201;  // A=[[1,2],[3,4]]
    localparam logic [31:0] WB = 32'h08070605;  // B=[[5,6],[7,8]]

    logic [31:0] feed_exp [1:8];
    logic [31:0] ctrl_exp [1:8];
    logic [31:0] ctrl4_exp[1:10];
    int          lat;
    int          ndone;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        feed_exp = '{32'h0, 32'h01000500, 32'h02030706, 32'h00040008,
                     32'h0, 32'h0, 32'h0, 32'h0};
        ctrl_exp = '{32'hA, 32'h9, 32'h9, 32'h9, 32'h9, 32'h9, 32'h8, 32'h4};
        ctrl4_exp = '{32'hA, 32'h9, 32'h9, 32'h9, 32'h9, 32'h9, 32'h9, 32'h9, 32'h8, 32'h4};

        bus.start = 1'b0; bus.weights = 32'd0; bus.inputs = 32'd0;
        bus.out_sel = 2'd0; bus.out_hi = 1'b0;
        bus4.start = 1'b0; bus4.weights = 32'd0; bus4.inputs = 32'd0;
        bus4.out_sel = 2'd0; bus4.out_hi = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ctrl", ctrl(1'b0), 32'h0);
        check("rst_feeds", feeds(1'b0), 32'h0);
        check("rst4_ctrl", ctrl4(1'b0), 32'h0);
        check_dout("rst_dout", 2'd3, 1'b1, 8'h00);

        // Basic run on both builds, start in cycle 0
        bus.weights = WA; bus.inputs = WB; bus.start = 1'b1;
        bus4.weights = WA; bus4.inputs = WB; bus4.start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            bus.start  = 1'b0;
            bus4.start = 1'b0;
            if (c <= 8) begin
                check($sformatf("basic_feed_c%0d", c), feeds(1'b0), feed_exp[c]);
                check($sformatf("basic_ctrl_c%0d", c), ctrl(1'b0), ctrl_exp[c]);
            end
            check($sformatf("drain4_ctrl_c%0d", c), ctrl4(1'b0), ctrl4_exp[c]);
        end
        check_dout("basic_c00_lo", 2'd0, 1'b0, 8'd19);
        check_dout("basic_c01_lo", 2'd1, 1'b0, 8'd22);
        check_dout("basic_c10_lo", 2'd2, 1'b0, 8'd43);
        check_dout("basic_c11_lo", 2'd3, 1'b0, 8'h32);
        check_dout("basic_c11_hi", 2'd3, 1'b1, 8'h00);

        // Signed extremes
        run_to_done(32'h80808080, 32'h80808080, lat);
        check("ext_latency", 32'(lat), 32'd8);
        check_dout("ext_c01_hi", 2'd1, 1'b1, 8'h80);
        check_dout("ext_c01_lo", 2'd1, 1'b0, 8'h00);
        check_dout("ext_c00_hi", 2'd0, 1'b1, 8'h80);
        check_dout("ext_c11_hi", 2'd3, 1'b1, 8'h80);

        // Operand latching with a stray start mid-run
        tick();
        bus.weights = WA; bus.inputs = WB; bus.start = 1'b1;
        bus.out_sel = 2'd3; bus.out_hi = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.start = 1'b0;
            if (c == 3) begin
                bus.weights = 32'h7F7F7F7F;
                bus.start   = 1'b1;
            end
            check($sformatf("latch_busy_c%0d", c), 32'(bus.busy), 32'(c <= 7));
            ndone += int'(bus.done);
        end
        check("latch_done_now", 32'(bus.done), 32'd1);
        check("latch_ndone", 32'(ndone), 32'd1);
        check_dout("latch_c11_lo", 2'd3, 1'b0, 8'h32);
        check_dout("latch_c10_lo", 2'd2, 1'b0, 8'd43);

        // Back-to-back: start in the done cycle with A=identity
        bus.weights = 32'h01000001; bus.inputs = WB; bus.start = 1'b1;
        bus.out_sel = 2'd3; bus.out_hi = 1'b0;
        tick();
        bus.start = 1'b0;
        check("b2b_clear", ctrl(1'b0), 32'hA);
        for (int c = 2; c <= 7; c++) begin
            tick();
            check($sformatf("b2b_hold_c%0d", c), 32'(bus.dout), 32'h32);
        end
        tick();
        check("b2b_done", 32'(bus.done), 32'd1);
        check_dout("b2b_c00", 2'd0, 1'b0, 8'd5);
        check_dout("b2b_c01", 2'd1, 1'b0, 8'd6);
        check_dout("b2b_c10", 2'd2, 1'b0, 8'd7);
        check_dout("b2b_c11", 2'd3, 1'b0, 8'd8);

        // Reset during F1
        tick();
        bus.weights = WA; bus.inputs = WB; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("rstmid_f1_feed", feeds(1'b0), 32'h02030706);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_ctrl", ctrl(1'b0), 32'h0);
        check("rstmid_feeds", feeds(1'b0), 32'h0);
        check_dout("rstmid_c11_lo", 2'd3, 1'b0, 8'h00);
        check_dout("rstmid_c01_lo", 2'd1, 1'b0, 8'h00);
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            ndone += int'(bus.done) + int'(bus.busy);
        end
        check("rstmid_quiet", 32'(ndone), 32'd0);

        // Reset and start together: reset wins
        rst = 1'b1; bus.start = 1'b1;
        tick();
        rst = 1'b0; bus.start = 1'b0;
        tick();
        check("rststart_idle", ctrl(1'b0), 32'h0);

        // Recovery run after the aborted one
        run_to_done(WA, WB, lat);
        check("recover_latency", 32'(lat), 32'd8);
        check_dout("recover_c00", 2'd0, 1'b0, 8'd19);
        check_dout("recover_c11", 2'd3, 1'b0, 8'h32);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
